// File: rtl/pwr_reg_pkg.sv
// Shared types and default widths for the register-bus arbiter slice.
package pwr_reg_pkg;

   localparam int DEF_DW = 8;
   localparam int DEF_AW = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC  = 2'd1,
      RSP  = 2'd2
   } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant. The pointer remembers which requester was served last,
// and it only moves when the top actually accepts the granted request.
module rr_arb2 (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic [1:0] i_req,
   input  logic       i_accept,
   output logic [1:0] o_gnt
);

   logic last_q; // 1 = requester 1 was served last

   always_comb begin
      // NOTE: o_gnt gets a default before any branch, so every path assigns it and no latch is inferred.
      o_gnt = i_req;
      if (i_req == 2'b11) begin
         o_gnt = last_q ? 2'b01 : 2'b10;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         last_q <= 1'b1;
      end else if (i_accept && (o_gnt != 2'b00)) begin
         last_q <= o_gnt[1];
      end
   end

endmodule

// File: rtl/reg_bus_arb.sv
// Arbitrates the SPI slave and the test engine onto one register bus.
// Each access runs IDLE -> ACC -> RSP; an illegal access skips ACC and never touches the bus.
module reg_bus_arb
   import pwr_reg_pkg::*;
#(
   parameter int DW = DEF_DW,
   parameter int AW = DEF_AW
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic          i_req0_vld,
   output logic          o_req0_rdy,
   input  logic          i_req0_wr,
   input  logic [AW-1:0] i_req0_addr,
   input  logic [DW-1:0] i_req0_wdata,
   output logic          o_rsp0_vld,
   output logic [DW-1:0] o_rsp0_rdata,
   output logic          o_rsp0_err,
   input  logic          i_req1_vld,
   output logic          o_req1_rdy,
   input  logic          i_req1_wr,
   input  logic [AW-1:0] i_req1_addr,
   input  logic [DW-1:0] i_req1_wdata,
   output logic          o_rsp1_vld,
   output logic [DW-1:0] o_rsp1_rdata,
   output logic          o_rsp1_err,
   output logic          o_wen,
   output logic          o_ren,
   output logic [AW-1:0] o_addr,
   output logic [DW-1:0] o_wdata,
   input  logic [DW-1:0] i_rdata,
   input  logic          i_test_mode_status,
   input  logic          i_cfg_mode_status
);

   state_e        state;
   logic [1:0]    gnt;
   logic          idle;
   logic          hs;
   logic          illegal;
   logic          sel_wr;
   logic [AW-1:0] sel_addr;
   logic [DW-1:0] sel_wdata;

   logic          wr_q;
   logic          id_q;
   logic          err_q;
   logic [AW-1:0] addr_q;
   logic [DW-1:0] wdata_q;
   logic [DW-1:0] rdata_q;

   rr_arb2 u_arb (
      .i_clk    (i_clk),
      .i_rst_n  (i_rst_n),
      .i_req    ({i_req1_vld, i_req0_vld}),
      .i_accept (hs),
      .o_gnt    (gnt)
   );

   assign idle      = (state == IDLE);
   assign hs        = idle && (gnt != 2'b00);
   assign sel_wr    = gnt[1] ? i_req1_wr    : i_req0_wr;
   assign sel_addr  = gnt[1] ? i_req1_addr  : i_req0_addr;
   assign sel_wdata = gnt[1] ? i_req1_wdata : i_req0_wdata;
   // The test engine may only run in test mode; anything needs at least one mode active.
   assign illegal   = (!i_test_mode_status && !i_cfg_mode_status) ||
                      (gnt[1] && !i_test_mode_status);

   // Ready is gated by reset so every output reads 0 while reset is held.
   assign o_req0_rdy = i_rst_n && idle && gnt[0];
   assign o_req1_rdy = i_rst_n && idle && gnt[1];

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state   <= IDLE;
         // NOTE: the captured payload is reset too, so an aborted access leaves nothing stale behind.
         wr_q    <= 1'b0;
         id_q    <= 1'b0;
         err_q   <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
         case (state)
            IDLE: begin
               if (hs) begin
                  wr_q    <= sel_wr;
                  id_q    <= gnt[1];
                  err_q   <= illegal;
                  addr_q  <= sel_addr;
                  wdata_q <= sel_wdata;
                  rdata_q <= '0;
                  state   <= illegal ? RSP : ACC;
               end
            end
            ACC: begin
               rdata_q <= wr_q ? '0 : i_rdata;
               state   <= RSP;
            end
            RSP:     state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign o_wen   = (state == ACC) &&  wr_q;
   assign o_ren   = (state == ACC) && !wr_q;
   assign o_addr  = (state == ACC) ? addr_q  : '0;
   assign o_wdata = (state == ACC) ? wdata_q : '0;

   assign o_rsp0_vld   = (state == RSP) && !id_q;
   assign o_rsp1_vld   = (state == RSP) &&  id_q;
   assign o_rsp0_rdata = o_rsp0_vld ? rdata_q : '0;
   assign o_rsp1_rdata = o_rsp1_vld ? rdata_q : '0;
   assign o_rsp0_err   = o_rsp0_vld && err_q;
   assign o_rsp1_err   = o_rsp1_vld && err_q;

endmodule

// File: tb/tb_reg_bus_arb.sv
// Directed bench for reg_bus_arb: inputs change just after the falling edge,
// outputs are checked 1 ns later, well away from the rising edge.
module tb_reg_bus_arb;

   logic       i_clk = 1'b0;
   logic       i_rst_n;
   logic       i_req0_vld, i_req0_wr, i_req1_vld, i_req1_wr;
   logic [7:0] i_req0_addr, i_req0_wdata, i_req1_addr, i_req1_wdata;
   logic       o_req0_rdy, o_req1_rdy;
   logic       o_rsp0_vld, o_rsp0_err, o_rsp1_vld, o_rsp1_err;
   logic [7:0] o_rsp0_rdata, o_rsp1_rdata;
   logic       o_wen, o_ren;
   logic [7:0] o_addr, o_wdata, i_rdata;
   logic       i_test_mode_status, i_cfg_mode_status;

   int n_checks = 0;
   int n_errors = 0;

   always #5 i_clk = ~i_clk;

   reg_bus_arb dut (
      .i_clk              (i_clk),
      .i_rst_n            (i_rst_n),
      .i_req0_vld         (i_req0_vld),
      .o_req0_rdy         (o_req0_rdy),
      .i_req0_wr          (i_req0_wr),
      .i_req0_addr        (i_req0_addr),
      .i_req0_wdata       (i_req0_wdata),
      .o_rsp0_vld         (o_rsp0_vld),
      .o_rsp0_rdata       (o_rsp0_rdata),
      .o_rsp0_err         (o_rsp0_err),
      .i_req1_vld         (i_req1_vld),
      .o_req1_rdy         (o_req1_rdy),
      .i_req1_wr          (i_req1_wr),
      .i_req1_addr        (i_req1_addr),
      .i_req1_wdata       (i_req1_wdata),
      .o_rsp1_vld         (o_rsp1_vld),
      .o_rsp1_rdata       (o_rsp1_rdata),
      .o_rsp1_err         (o_rsp1_err),
      .o_wen              (o_wen),
      .o_ren              (o_ren),
      .o_addr             (o_addr),
      .o_wdata            (o_wdata),
      .i_rdata            (i_rdata),
      .i_test_mode_status (i_test_mode_status),
      .i_cfg_mode_status  (i_cfg_mode_status)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic next_cycle();
      @(negedge i_clk);
   endtask

   initial begin
      i_rst_n = 1'b0;
      i_req0_vld = 1'b1; i_req0_wr = 1'b0; i_req0_addr = 8'h40; i_req0_wdata = 8'h00;
      i_req1_vld = 1'b1; i_req1_wr = 1'b0; i_req1_addr = 8'h41; i_req1_wdata = 8'h00;
      i_rdata = 8'h5A;
      i_test_mode_status = 1'b1;
      i_cfg_mode_status  = 1'b0;

      // Held in reset with both requesters asking: everything must stay quiet.
      repeat (2) next_cycle();
      #1;
      check("rst_rdy",  {o_req1_rdy, o_req0_rdy}, 2'b00);
      check("rst_bus",  {o_wen, o_ren, o_addr, o_wdata}, 18'h0);
      check("rst_rsp",  {o_rsp1_vld, o_rsp0_vld, o_rsp1_err, o_rsp0_err}, 4'h0);

      // Release with both requesters valid: first edge must accept, grants alternate 0,1,0,1.
      i_rst_n = 1'b1;
      #1;
      for (int g = 0; g < 4; g++) begin
         automatic logic owner = 1'(g % 2);
         check("rr_rdy",  {o_req1_rdy, o_req0_rdy}, owner ? 2'b10 : 2'b01);
         next_cycle(); #1;
         check("rr_acc_rdy", {o_req1_rdy, o_req0_rdy}, 2'b00);
         check("rr_ren",  {o_wen, o_ren}, 2'b01);
         check("rr_addr", o_addr, owner ? 8'h41 : 8'h40);
         next_cycle(); #1;
         check("rr_rsp_vld", {o_rsp1_vld, o_rsp0_vld}, owner ? 2'b10 : 2'b01);
         check("rr_rsp_rdata", owner ? o_rsp1_rdata : o_rsp0_rdata, 8'h5A);
         check("rr_rsp_rdy", {o_req1_rdy, o_req0_rdy}, 2'b00);
         next_cycle(); #1;
      end
      i_req0_vld = 1'b0; i_req1_vld = 1'b0;
      #1;
      check("rr_done_rdy", {o_req1_rdy, o_req0_rdy}, 2'b00);

      // cfg-mode write from req0; i_rdata is nonzero to prove a write returns 0.
      i_test_mode_status = 1'b0; i_cfg_mode_status = 1'b1;
      i_req0_vld = 1'b1; i_req0_wr = 1'b1; i_req0_addr = 8'h12; i_req0_wdata = 8'hA5;
      i_rdata = 8'hFF;
      #1;
      check("wr_rdy0", o_req0_rdy, 1'b1);
      next_cycle(); i_req0_vld = 1'b0; #1;
      check("wr_strobes", {o_wen, o_ren}, 2'b10);
      check("wr_addr",  o_addr,  8'h12);
      check("wr_wdata", o_wdata, 8'hA5);
      check("wr_no_early_rsp", o_rsp0_vld, 1'b0);
      next_cycle(); #1;
      check("wr_rsp", {o_rsp1_vld, o_rsp0_vld, o_rsp0_err}, 3'b010);
      check("wr_rsp_rdata", o_rsp0_rdata, 8'h00);
      check("wr_bus_idle", {o_wen, o_ren, o_addr, o_wdata}, 18'h0);
      next_cycle(); #1;
      check("wr_rsp_gone", o_rsp0_vld, 1'b0);

      // cfg-mode read from req0; i_rdata changes after ACC to prove it was captured.
      i_req0_vld = 1'b1; i_req0_wr = 1'b0; i_req0_addr = 8'h12; i_rdata = 8'h3C;
      #1;
      check("rd_rdy0", o_req0_rdy, 1'b1);
      next_cycle(); i_req0_vld = 1'b0; #1;
      check("rd_strobes", {o_wen, o_ren}, 2'b01);
      check("rd_addr", o_addr, 8'h12);
      next_cycle(); i_rdata = 8'h00; #1;
      check("rd_rsp0_vld", o_rsp0_vld, 1'b1);
      check("rd_rsp0_rdata", o_rsp0_rdata, 8'h3C);
      check("rd_rsp1_quiet", {o_rsp1_vld, o_rsp1_rdata}, 9'h0);
      next_cycle(); #1;
      check("rd_rdata_zero", {o_rsp0_vld, o_rsp0_rdata}, 9'h0);

      // Test engine in cfg-only mode: rejected, response one cycle after acceptance.
      i_req1_vld = 1'b1; i_req1_wr = 1'b0; i_req1_addr = 8'h20; i_rdata = 8'h77;
      #1;
      check("ill1_rdy1", o_req1_rdy, 1'b1);
      next_cycle(); i_req1_vld = 1'b0; #1;
      check("ill1_no_bus", {o_wen, o_ren}, 2'b00);
      check("ill1_rsp", {o_rsp0_vld, o_rsp1_vld, o_rsp1_err}, 3'b011);
      check("ill1_rdata", o_rsp1_rdata, 8'h00);
      next_cycle(); #1;
      check("ill1_rsp_gone", o_rsp1_vld, 1'b0);

      // No mode at all: req0 write rejected.
      i_cfg_mode_status = 1'b0;
      i_req0_vld = 1'b1; i_req0_wr = 1'b1; i_req0_addr = 8'h30; i_req0_wdata = 8'h11;
      #1;
      check("ill0_rdy0", o_req0_rdy, 1'b1);
      next_cycle(); i_req0_vld = 1'b0; #1;
      check("ill0_no_wen", o_wen, 1'b0);
      check("ill0_rsp", {o_rsp0_vld, o_rsp0_err}, 2'b11);
      next_cycle(); #1;

      // Mode dropped after acceptance must not disturb the in-flight write.
      i_cfg_mode_status = 1'b1;
      i_req0_vld = 1'b1; i_req0_wr = 1'b1; i_req0_addr = 8'h55; i_req0_wdata = 8'h66;
      #1;
      check("mode_rdy0", o_req0_rdy, 1'b1);
      next_cycle(); i_req0_vld = 1'b0; i_cfg_mode_status = 1'b0; #1;
      check("mode_wen", {o_wen, o_addr, o_wdata}, 17'h15566);
      next_cycle(); #1;
      check("mode_rsp", {o_rsp0_vld, o_rsp0_err}, 2'b10);
      next_cycle(); #1;

      // Reset pulse during ACC aborts the access; next request accepted on first edge after release.
      i_cfg_mode_status = 1'b1;
      i_req0_vld = 1'b1; i_req0_wr = 1'b1; i_req0_addr = 8'h7E; i_req0_wdata = 8'h81;
      next_cycle(); i_req0_vld = 1'b0; #1;
      check("abort_acc_wen", o_wen, 1'b1);
      i_rst_n = 1'b0;
      #1;
      check("abort_bus_zero", {o_wen, o_ren, o_addr, o_wdata}, 18'h0);
      check("abort_no_rsp", o_rsp0_vld, 1'b0);
      next_cycle(); #1;
      check("abort_still_no_rsp", {o_rsp1_vld, o_rsp0_vld}, 2'b00);
      i_rst_n = 1'b1;
      i_req0_vld = 1'b1; i_req0_wr = 1'b0; i_req0_addr = 8'h09; i_rdata = 8'h42;
      #1;
      check("post_rst_rdy0", o_req0_rdy, 1'b1);
      next_cycle(); i_req0_vld = 1'b0; #1;
      check("post_rst_ren", {o_wen, o_ren, o_addr}, 10'h009 | 10'h100);
      next_cycle(); #1;
      check("post_rst_rsp", {o_rsp0_vld, o_rsp0_err, o_rsp0_rdata}, 10'h242);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
